// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access sequencer.
// Holds the pipeline stall-bus layout, load/store access type codes,
// the sequencer state encoding and the alignment rule.
package dmem_access_ctrl_pkg;

    // Pipeline stall bus: one bit per stage, [0] PC .. [5] WB.
    localparam int unsigned STALL_W   = 6;
    localparam int unsigned STAGE_MEM = 4;
    localparam logic        STOP      = 1'b1;
    localparam logic        NO_STOP   = 1'b0;

    // Wait counter wide enough for latencies up to 15.
    localparam int unsigned CNT_W = 4;

    // Access type codes.
    localparam logic [2:0] LT_BS = 3'b000;
    localparam logic [2:0] LT_BU = 3'b001;
    localparam logic [2:0] LT_HS = 3'b010;
    localparam logic [2:0] LT_HU = 3'b011;
    localparam logic [2:0] LT_W  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Halves need an even address, words a multiple of four.
    function automatic logic is_aligned(input logic [2:0] acc_type, input logic [1:0] addr_lo);
        case (acc_type)
            LT_BS, LT_BU: is_aligned = 1'b1;
            LT_HS, LT_HU: is_aligned = ~addr_lo[0];
            default:      is_aligned = (addr_lo == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the data SRAM port.
// Ports:
//   type_i    access type code
//   addr_lo_i low two address bits (lane offset)
//   wdata_i   right-aligned store data
//   rdata_i   raw SRAM word
//   wen_o     byte write mask shifted to the addressed lanes
//   wdata_o   store data replicated across lanes
//   rdata_o   selected byte/half, sign- or zero-extended
module lsu_lane_align
    import dmem_access_ctrl_pkg::*;
(
    input  logic [2:0]  type_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wen_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] rshift_c;

    // Store side: mask and replicate so any lane offset finds its data.
    always_comb begin
        wen_o   = 4'b1111;
        wdata_o = wdata_i;
        case (type_i)
            LT_BS, LT_BU: begin
                wen_o   = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            LT_HS, LT_HU: begin
                wen_o   = 4'b0011 << addr_lo_i;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                wen_o   = 4'b1111;
                wdata_o = wdata_i;
            end
        endcase
    end

    // Load side: bring the addressed lane down to bit 0, then extend.
    assign rshift_c = rdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        rdata_o = rshift_c;
        case (type_i)
            LT_BS:   rdata_o = {{24{rshift_c[7]}}, rshift_c[7:0]};
            LT_BU:   rdata_o = {24'h000000, rshift_c[7:0]};
            LT_HS:   rdata_o = {{16{rshift_c[15]}}, rshift_c[15:0]};
            LT_HU:   rdata_o = {16'h0000, rshift_c[15:0]};
            default: rdata_o = rshift_c;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data SRAM access sequencer shared by EX and MEM.
// Accepts one load/store, presents it to the SRAM for one cycle, counts the
// fixed read latency while requesting a MEM stall, then holds the extended
// load result until MEM advances.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   stall[5:0]                pipeline stall bus (bit 4 = MEM)
//   req_en/we/type/addr/wdata request from EX
//   data_sram_*               SRAM port (decoded from state + request regs)
//   stallreq_mem              hold request to stall controller
//   load_data, load_valid     extended load result for MEM
//   misalign                  pulse when a misaligned request is dropped
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        req_en,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata,
    output logic        stallreq_mem,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [2:0]       type_q, type_d;
    logic             we_q, we_d;
    logic [31:0]      load_data_q, load_data_d;
    logic             load_valid_q, load_valid_d;
    logic             stallreq_q, stallreq_d;
    logic             misalign_q, misalign_d;

    logic             aligned_c;
    logic             accept_c;
    logic             access_c;
    logic [3:0]       lane_wen_c;
    logic [31:0]      lane_wdata_c;
    logic [31:0]      lane_rdata_c;
    logic             unused_stall_c;

    // Only the MEM bit of the stall bus steers this block.
    assign unused_stall_c = ^{stall[5], stall[3:0]};

    assign aligned_c = is_aligned(req_type, req_addr[1:0]);

    lsu_lane_align u_lane (
        .type_i    (type_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (data_sram_rdata),
        .wen_o     (lane_wen_c),
        .wdata_o   (lane_wdata_c),
        .rdata_o   (lane_rdata_c)
    );

    // State, counter, request capture and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            type_q       <= '0;
            we_q         <= 1'b0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            stallreq_q   <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            type_q       <= type_d;
            we_q         <= we_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            stallreq_q   <= stallreq_d;
            misalign_q   <= misalign_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        type_d       = type_q;
        we_d         = we_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        stallreq_d   = 1'b0;
        misalign_d   = 1'b0;
        accept_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_en) begin
                    accept_c   = aligned_c;
                    misalign_d = ~aligned_c;
                end
            end
            ST_ACCESS: begin
                if (we_q) begin
                    state_d = ST_IDLE;
                end else if (WAIT_CYCLES <= 1) begin
                    state_d      = ST_DONE;
                    load_data_d  = lane_rdata_c;
                    load_valid_d = 1'b1;
                end else begin
                    state_d    = ST_WAIT;
                    cnt_d      = CNT_W'(WAIT_CYCLES - 1);
                    stallreq_d = 1'b1;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Counter about to hit zero: rdata is valid this cycle.
                if (cnt_q == CNT_W'(1)) begin
                    state_d      = ST_DONE;
                    load_data_d  = lane_rdata_c;
                    load_valid_d = 1'b1;
                end else begin
                    stallreq_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (stall[STAGE_MEM] == NO_STOP) begin
                    state_d = ST_IDLE;
                    if (req_en) begin
                        accept_c   = aligned_c;
                        misalign_d = ~aligned_c;
                    end
                end else begin
                    load_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new request goes straight to ACCESS; loads stall from that cycle.
        if (accept_c) begin
            state_d    = ST_ACCESS;
            addr_d     = req_addr;
            wdata_d    = req_wdata;
            type_d     = req_type;
            we_d       = req_we;
            stallreq_d = ~req_we;
        end
    end

    // SRAM port is only non-zero during ACCESS.
    assign access_c        = (state_q == ST_ACCESS);
    assign data_sram_en    = access_c;
    assign data_sram_wen   = (access_c && we_q) ? lane_wen_c : 4'b0000;
    assign data_sram_addr  = access_c ? {addr_q[31:2], 2'b00} : 32'h0000_0000;
    assign data_sram_wdata = (access_c && we_q) ? lane_wdata_c : 32'h0000_0000;

    assign stallreq_mem = stallreq_q;
    assign load_data    = load_data_q;
    assign load_valid   = load_valid_q;
    assign misalign     = misalign_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl with WAIT_CYCLES=2.
// A small SRAM model answers reads one cycle after the enable cycle; a
// transaction-level reference (byte array arithmetic) predicts every result.
module tb_dmem_access_ctrl;
    import dmem_access_ctrl_pkg::*;

    localparam int unsigned WC = 2;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        req_en;
    logic        req_we;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq_mem;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] ref_mem [0:255];
    logic [31:0] sram    [0:255];
    logic        poke_en;
    logic [7:0]  poke_idx;
    logic [31:0] poke_val;

    dmem_access_ctrl #(.WAIT_CYCLES(WC)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .req_en          (req_en),
        .req_we          (req_we),
        .req_type        (req_type),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .stallreq_mem    (stallreq_mem),
        .load_data       (load_data),
        .load_valid      (load_valid),
        .misalign        (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: 1-cycle synchronous read, byte-masked writes, bench pokes.
    always @(posedge clk) begin
        if (poke_en) begin
            sram[poke_idx] <= poke_val;
        end else if (data_sram_en) begin
            for (int b = 0; b < 4; b++)
                if (data_sram_wen[b]) sram[data_sram_addr[9:2]][8*b +: 8] <= data_sram_wdata[8*b +: 8];
            if (data_sram_wen == 4'b0000) data_sram_rdata <= sram[data_sram_addr[9:2]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [7:0] idx, input logic [31:0] val);
        poke_idx = idx;
        poke_val = val;
        poke_en  = 1'b1;
        tick();
        poke_en  = 1'b0;
        ref_mem[idx] = val;
    endtask

    function automatic int size_of(input logic [2:0] t);
        case (t)
            LT_BS, LT_BU: return 1;
            LT_HS, LT_HU: return 2;
            default:      return 4;
        endcase
    endfunction

    // Reference load result: pick bytes numerically, extend by value range.
    function automatic logic [31:0] exp_load(input logic [2:0] t, input logic [31:0] addr, input logic [31:0] word);
        int     sz;
        int     off;
        longint v;
        sz  = size_of(t);
        off = int'(addr[1:0]);
        if (sz == 4) return word;
        v = longint'(word >> (8 * off)) & ((longint'(1) << (8 * sz)) - 1);
        if ((t == LT_BS || t == LT_HS) && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        return 32'(v);
    endfunction

    function automatic logic [3:0] exp_wen(input logic [2:0] t, input logic [31:0] addr);
        return 4'(((1 << size_of(t)) - 1) << int'(addr[1:0]));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] t, input logic [31:0] wd);
        case (size_of(t))
            1:       return (wd & 32'hFF) * 32'h0101_0101;
            2:       return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    // One transaction from IDLE (or already issued from DONE). Loads end in
    // DONE when rel=0, otherwise MEM is released after 'hold' stalled cycles.
    task automatic run_txn(input logic we, input logic [2:0] t, input logic [31:0] addr,
                           input logic [31:0] wd, input int hold, input bit issued,
                           input bit rel, output logic [31:0] got);
        int          sz;
        int          off;
        int          lat;
        int          sc;
        int          ec;
        logic [31:0] exp;
        logic [31:0] w;
        sz  = size_of(t);
        off = int'(addr[1:0]);
        got = '0;
        if (!issued) begin
            req_en = 1'b1; req_we = we; req_type = t; req_addr = addr; req_wdata = wd;
            tick();
        end
        req_en = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        if ((off % sz) != 0) begin
            n_cmp++;
            if ({data_sram_en, misalign, stallreq_mem} !== 3'b010) begin
                n_err++;
                $display("FAIL misalign_pulse addr=%h: en/mis/stallreq got %b want 010", addr, {data_sram_en, misalign, stallreq_mem});
            end
            tick();
            n_cmp++;
            if ({data_sram_en, misalign, stallreq_mem} !== 3'b000) begin
                n_err++;
                $display("FAIL misalign_end addr=%h: en/mis/stallreq got %b want 000", addr, {data_sram_en, misalign, stallreq_mem});
            end
            return;
        end
        n_cmp++;
        if (data_sram_en !== 1'b1 || data_sram_addr !== {addr[31:2], 2'b00}) begin
            n_err++;
            $display("FAIL access addr=%h: en=%b sram_addr=%h want en=1 sram_addr=%h", addr, data_sram_en, data_sram_addr, {addr[31:2], 2'b00});
        end
        if (we) begin
            n_cmp++;
            if (data_sram_wen !== exp_wen(t, addr) || data_sram_wdata !== exp_wdata(t, wd) || stallreq_mem !== 1'b0) begin
                n_err++;
                $display("FAIL store addr=%h t=%0d: wen=%b wdata=%h stallreq=%b want wen=%b wdata=%h stallreq=0",
                         addr, t, data_sram_wen, data_sram_wdata, stallreq_mem, exp_wen(t, addr), exp_wdata(t, wd));
            end
            w = ref_mem[addr[9:2]];
            for (int i = 0; i < sz; i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
            ref_mem[addr[9:2]] = w;
            tick();
            n_cmp++;
            if (data_sram_en !== 1'b0 || stallreq_mem !== 1'b0) begin
                n_err++;
                $display("FAIL store_end: en=%b stallreq=%b want 0 0", data_sram_en, stallreq_mem);
            end
            return;
        end
        n_cmp++;
        if (data_sram_wen !== 4'b0000) begin
            n_err++;
            $display("FAIL load_wen addr=%h: got %b want 0000", addr, data_sram_wen);
        end
        lat = 0; sc = 0; ec = 0;
        while (load_valid !== 1'b1 && lat < 20) begin
            if (stallreq_mem === 1'b1) sc++;
            if (data_sram_en === 1'b1) ec++;
            tick();
            lat++;
        end
        n_cmp++;
        if (lat != int'(WC) || sc != int'(WC) || ec != 1) begin
            n_err++;
            $display("FAIL load_timing addr=%h: latency=%0d stallreq_cycles=%0d en_cycles=%0d want %0d %0d 1", addr, lat, sc, ec, WC, WC);
        end
        exp = exp_load(t, addr, ref_mem[addr[9:2]]);
        n_cmp++;
        if (load_data !== exp || stallreq_mem !== 1'b0) begin
            n_err++;
            $display("FAIL load_data addr=%h t=%0d: got %h stallreq=%b want %h stallreq=0", addr, t, load_data, stallreq_mem, exp);
        end
        got = load_data;
        for (int h = 0; h < hold; h++) begin
            stall[STAGE_MEM] = STOP;
            tick();
            n_cmp++;
            if (load_valid !== 1'b1 || load_data !== exp || data_sram_en !== 1'b0) begin
                n_err++;
                $display("FAIL done_hold cycle %0d: valid=%b data=%h en=%b want 1 %h 0", h, load_valid, load_data, data_sram_en, exp);
            end
        end
        if (rel) begin
            stall[STAGE_MEM] = ~STOP;
            tick();
            n_cmp++;
            if (load_valid !== 1'b0 || data_sram_en !== 1'b0) begin
                n_err++;
                $display("FAIL done_release: valid=%b en=%b want 0 0", load_valid, data_sram_en);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = '0; req_en = 1'b0; req_we = 1'b0; req_type = '0;
        req_addr = '0; req_wdata = '0; poke_en = 1'b0; poke_idx = '0; poke_val = '0;
        tick();
        tick();
        n_cmp++;
        if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, stallreq_mem, load_data, load_valid, misalign} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: en=%b wen=%b addr=%h wdata=%h stallreq=%b ld=%h lv=%b mis=%b want all 0",
                     data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, stallreq_mem, load_data, load_valid, misalign);
        end
        for (int i = 0; i < 256; i++) poke(8'(i), $urandom);
        rst = 1'b0;
    endtask

    task automatic test_word_load();
        logic [31:0] g;
        poke(8'h40, 32'hDEAD_BEEF);
        run_txn(1'b0, LT_W, 32'h100, 32'h0, 0, 1'b0, 1'b1, g);
        n_cmp++;
        if (g !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL word_load: got %h want deadbeef", g); end
    endtask

    task automatic test_byte_load();
        logic [31:0] g;
        poke(8'h40, 32'h80FF_0000);
        run_txn(1'b0, LT_BS, 32'h103, 32'h0, 1, 1'b0, 1'b1, g);
        n_cmp++;
        if (g !== 32'hFFFF_FF80) begin n_err++; $display("FAIL byte_signed: got %h want ffffff80", g); end
        run_txn(1'b0, LT_BU, 32'h103, 32'h0, 0, 1'b0, 1'b1, g);
        n_cmp++;
        if (g !== 32'h0000_0080) begin n_err++; $display("FAIL byte_unsigned: got %h want 00000080", g); end
    endtask

    task automatic test_half_store();
        logic [31:0] g;
        req_en = 1'b1; req_we = 1'b1; req_type = LT_HS; req_addr = 32'h202; req_wdata = 32'hABCD_1234;
        tick();
        req_en = 1'b0;
        n_cmp++;
        if (data_sram_en !== 1'b1 || data_sram_wen !== 4'b1100 || data_sram_wdata !== 32'h1234_1234 ||
            data_sram_addr !== 32'h200 || stallreq_mem !== 1'b0) begin
            n_err++;
            $display("FAIL half_store: en=%b wen=%b wdata=%h addr=%h stallreq=%b want 1 1100 12341234 00000200 0",
                     data_sram_en, data_sram_wen, data_sram_wdata, data_sram_addr, stallreq_mem);
        end
        ref_mem[8'h80][31:16] = 16'h1234;
        tick();
        n_cmp++;
        if (data_sram_en !== 1'b0 || stallreq_mem !== 1'b0) begin
            n_err++;
            $display("FAIL half_store_end: en=%b stallreq=%b want 0 0", data_sram_en, stallreq_mem);
        end
        run_txn(1'b0, LT_HU, 32'h202, 32'h0, 0, 1'b0, 1'b1, g);
        n_cmp++;
        if (g !== 32'h0000_1234) begin n_err++; $display("FAIL half_readback: got %h want 00001234", g); end
    endtask

    task automatic test_misalign();
        logic [31:0] g;
        run_txn(1'b0, LT_W, 32'h101, 32'h0, 0, 1'b0, 1'b1, g);
        run_txn(1'b1, LT_HS, 32'h203, 32'h5555, 0, 1'b0, 1'b1, g);
        poke(8'h40, 32'h0BAD_F00D);
        run_txn(1'b0, LT_W, 32'h100, 32'h0, 0, 1'b0, 1'b1, g);
        n_cmp++;
        if (g !== 32'h0BAD_F00D) begin n_err++; $display("FAIL after_misalign: got %h want 0badf00d", g); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] g;
        poke(8'h40, 32'h1357_9BDF);
        poke(8'h41, 32'hCAFE_0000);
        run_txn(1'b0, LT_W, 32'h100, 32'h0, 3, 1'b0, 1'b0, g);
        n_cmp++;
        if (g !== 32'h1357_9BDF) begin n_err++; $display("FAIL b2b_first: got %h want 13579bdf", g); end
        req_en = 1'b1; req_we = 1'b0; req_type = LT_HU; req_addr = 32'h106; req_wdata = '0;
        stall[STAGE_MEM] = ~STOP;
        tick();
        run_txn(1'b0, LT_HU, 32'h106, 32'h0, 0, 1'b1, 1'b1, g);
        n_cmp++;
        if (g !== 32'h0000_CAFE) begin n_err++; $display("FAIL b2b_second: got %h want 0000cafe", g); end
    endtask

    task automatic test_reset_wait();
        logic [31:0] g;
        req_en = 1'b1; req_we = 1'b0; req_type = LT_W; req_addr = 32'h104; req_wdata = '0;
        tick();
        req_en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, stallreq_mem, load_data, load_valid, misalign} !== '0) begin
            n_err++;
            $display("FAIL reset_in_wait: en=%b stallreq=%b ld=%h lv=%b mis=%b want all 0",
                     data_sram_en, stallreq_mem, load_data, load_valid, misalign);
        end
        run_txn(1'b0, LT_W, 32'h104, 32'h0, 0, 1'b0, 1'b1, g);
    endtask

    task automatic test_random();
        logic [31:0] g;
        logic        we;
        logic [2:0]  t;
        for (int n = 0; n < 120; n++) begin
            we = 1'($urandom_range(0, 1));
            t  = we ? 3'(2 * $urandom_range(0, 2)) : 3'($urandom_range(0, 4));
            stall = {1'($urandom), 1'b0, 4'($urandom)};
            run_txn(we, t, $urandom, $urandom, int'($urandom_range(0, 2)), 1'b0, 1'b1, g);
        end
        stall = '0;
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_store();
        test_misalign();
        test_back_to_back();
        test_reset_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
